// File: rtl/gf2m_pkg.sv
// Shared types and helpers for the GF(2^M) Itoh-Tsujii inverter.
// Field helpers use a fixed maximum width so one function serves every instance width.
package gf2m_pkg;

    localparam int MAX_M = 256;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQR_D = 3'd1,
        S_MUL_D = 3'd2,
        S_SQR_A = 3'd3,
        S_MUL_A = 3'd4,
        S_FSQ   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Square x modulo (x^m + poly): spread bits to even positions, then fold the top half down.
    function automatic logic [MAX_M-1:0] gf2m_sqr(input logic [MAX_M-1:0] x,
                                                  input logic [MAX_M-1:0] poly,
                                                  input int m);
        logic [2*MAX_M-1:0] y;
        y = '0;
        for (int i = 0; i < MAX_M; i++) begin
            if (i < m) y[2*i] = x[i];
        end
        for (int i = 2*MAX_M-2; i >= 1; i--) begin
            if (i >= m && i <= 2*m-2 && y[i]) begin
                y[i] = 1'b0;
                y    = y ^ ({{MAX_M{1'b0}}, poly} << (i - m));
            end
        end
        return y[MAX_M-1:0];
    endfunction

    function automatic int msb_index(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic int gf2m_l_mul(input int m, input int digit);
        return (m + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/gf2m_inv_chain_mul.sv
// MSB-first digit-serial GF(2^M) multiplier; DONE pulses L_MUL cycles after START.
// The first digit is consumed on the START edge so the result lands exactly on time.
module gf2m_mul_digit
    import gf2m_pkg::*;
#(
    parameter int          M     = 233,
    parameter logic [M-1:0] POLY = M'((233'd1 << 74) | 233'd1),
    parameter int          DIGIT = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         ABORT,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         DONE,
    output logic [M-1:0] P
);

    localparam int L_MUL = gf2m_l_mul(M, DIGIT);
    localparam int PW    = L_MUL * DIGIT;
    localparam int CW    = (L_MUL > 1) ? $clog2(L_MUL) : 1;

    logic [M-1:0]  acc_q, acc_d, a_q, a_d;
    logic [PW-1:0] b_q, b_d, b_pad;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc,
                                                input logic [M-1:0] a,
                                                input logic [DIGIT-1:0] d);
        logic [M-1:0] r;
        r = acc;
        for (int i = DIGIT-1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0) ^ (d[i] ? a : '0);
        end
        return r;
    endfunction

    // Zero-extend at the top so padding digits are leading zeros, not extra x factors.
    assign b_pad = PW'(B);
    assign DONE  = busy_q && (cnt_q == '0);
    assign P     = acc_q;

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (ABORT) begin
            acc_d  = '0;
            a_d    = '0;
            b_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (START) begin
            acc_d  = digit_step('0, A, b_pad[PW-1 -: DIGIT]);
            a_d    = A;
            b_d    = b_pad << DIGIT;
            cnt_d  = CW'(L_MUL - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                acc_d = digit_step(acc_q, a_q, b_q[PW-1 -: DIGIT]);
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q - CW'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/gf2m_inv_chain.sv
// Itoh-Tsujii inverter: beta_k = a^(2^k-1) grown along an addition chain taken from the bits of M-1,
// finished by one squaring to give a^(2^M-2) = a^-1.
module gf2m_inv_chain
    import gf2m_pkg::*;
#(
    parameter int           M            = 233,
    parameter logic [M-1:0] POLY         = M'((233'd1 << 74) | 233'd1),
    parameter int           SQ_PER_CYCLE = 4,
    parameter int           DIGIT        = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [M-1:0] DIN,
    input  logic         ABORT,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [M-1:0] DOUT,
    output logic         ZERO_ERR
);

    localparam int  KW          = $clog2(M);
    localparam int  JW          = $clog2(M);
    localparam int  M1W         = 1 << JW;
    localparam int  NW          = $clog2(SQ_PER_CYCLE + 1);
    localparam bit  CHAIN_EMPTY = (M - 1 == 1);
    localparam int  J_START     = CHAIN_EMPTY ? 0 : msb_index(M - 1) - 1;
    localparam logic [M1W-1:0] M1_BITS = M1W'(M - 1);

    state_t        state_q, state_d;
    logic [M-1:0]  a_q, a_d, beta_q, beta_d, t_q, t_d, dout_q, dout_d;
    logic [KW-1:0] k_q, k_d, r_q, r_d;
    logic [JW-1:0] j_q, j_d;
    logic          issued_q, issued_d, out_valid_q, out_valid_d, zero_err_q, zero_err_d;
    logic [M-1:0]  sq_chain [0:SQ_PER_CYCLE];
    logic [NW-1:0] n_sq;
    logic          mul_start, mul_done;
    logic [M-1:0]  mul_b, mul_p;

    assign sq_chain[0] = beta_q;
    generate
        for (genvar gi = 0; gi < SQ_PER_CYCLE; gi++) begin : g_sq
            assign sq_chain[gi+1] = M'(gf2m_sqr(MAX_M'(sq_chain[gi]), MAX_M'(POLY), M));
        end
    endgenerate

    assign n_sq      = (int'(r_q) >= SQ_PER_CYCLE) ? NW'(SQ_PER_CYCLE) : NW'(r_q);
    assign mul_start = (state_q == S_MUL_D || state_q == S_MUL_A) && !issued_q && !ABORT;
    assign mul_b     = (state_q == S_MUL_D) ? t_q : a_q;

    gf2m_mul_digit #(.M(M), .POLY(POLY), .DIGIT(DIGIT)) u_mul (
        .CLK   (CLK),
        .RST   (RST),
        .START (mul_start),
        .ABORT (ABORT),
        .A     (beta_q),
        .B     (mul_b),
        .DONE  (mul_done),
        .P     (mul_p)
    );

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = out_valid_q;
    assign DOUT      = dout_q;
    assign ZERO_ERR  = zero_err_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        beta_d      = beta_q;
        t_d         = t_q;
        dout_d      = dout_q;
        k_d         = k_q;
        r_d         = r_q;
        j_d         = j_q;
        issued_d    = issued_q;
        out_valid_d = out_valid_q;
        zero_err_d  = zero_err_q;
        case (state_q)
            S_IDLE: if (IN_VALID) begin
                a_d        = DIN;
                beta_d     = DIN;
                t_d        = DIN;
                k_d        = KW'(1);
                r_d        = KW'(1);
                j_d        = JW'(J_START);
                zero_err_d = (DIN == '0);
                // A zero operand squares to zero in FSQ, giving DOUT=0 one cycle later.
                state_d    = (DIN == '0 || CHAIN_EMPTY) ? S_FSQ : S_SQR_D;
            end
            S_SQR_D: begin
                beta_d = sq_chain[n_sq];
                r_d    = r_q - KW'(n_sq);
                if (r_q == KW'(n_sq)) begin
                    issued_d = 1'b0;
                    state_d  = S_MUL_D;
                end
            end
            S_MUL_D: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (mul_done) begin
                    beta_d = mul_p;
                    k_d    = k_q << 1;
                    if (M1_BITS[j_q]) begin
                        state_d = S_SQR_A;
                    end else if (j_q == '0) begin
                        state_d = S_FSQ;
                    end else begin
                        j_d     = j_q - JW'(1);
                        r_d     = k_q << 1;
                        t_d     = mul_p;
                        state_d = S_SQR_D;
                    end
                end
            end
            S_SQR_A: begin
                beta_d   = sq_chain[1];
                issued_d = 1'b0;
                state_d  = S_MUL_A;
            end
            S_MUL_A: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (mul_done) begin
                    beta_d = mul_p;
                    k_d    = k_q + KW'(1);
                    if (j_q == '0) begin
                        state_d = S_FSQ;
                    end else begin
                        j_d     = j_q - JW'(1);
                        r_d     = k_q + KW'(1);
                        t_d     = mul_p;
                        state_d = S_SQR_D;
                    end
                end
            end
            S_FSQ: begin
                dout_d      = sq_chain[1];
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: if (OUT_READY) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (ABORT && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            issued_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            beta_q      <= '0;
            t_q         <= '0;
            dout_q      <= '0;
            k_q         <= '0;
            r_q         <= '0;
            j_q         <= '0;
            issued_q    <= 1'b0;
            out_valid_q <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            beta_q      <= beta_d;
            t_q         <= t_d;
            dout_q      <= dout_d;
            k_q         <= k_d;
            r_q         <= r_d;
            j_q         <= j_d;
            issued_q    <= issued_d;
            out_valid_q <= out_valid_d;
            zero_err_q  <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_gf2m_inv_chain.sv
// Bench for gf2m_inv_chain: directed GF(2^8) cases plus random GF(2^233) operands on three
// squarer widths, checked against a bit-serial field model and brute-force inversion.
module tb_gf2m_inv_chain;

    localparam logic [255:0] P8   = 256'h1B;
    localparam logic [255:0] P233 = (256'd1 << 74) | 256'd1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       in_valid8 = 1'b0, abort8 = 1'b0, out_ready8 = 1'b1;
    logic       in_ready8, out_valid8, zero8;
    logic [7:0] din8 = 8'h00, dout8;

    logic           iv_b = 1'b0, ab_b = 1'b0, or_b = 1'b0;
    logic [232:0]   din_b = '0;
    logic [2:0]     ir_b, ov_b, ze_b;
    logic [232:0]   dout_b [3];

    int n_assert = 0;
    int n_fail   = 0;

    gf2m_inv_chain #(.M(8), .POLY(8'h1B), .SQ_PER_CYCLE(1), .DIGIT(1)) u_dut8 (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid8), .IN_READY(in_ready8), .DIN(din8),
        .ABORT(abort8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .DOUT(dout8),
        .ZERO_ERR(zero8));

    gf2m_inv_chain #(.M(233), .SQ_PER_CYCLE(1), .DIGIT(8)) u_dut_sq1 (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_b), .IN_READY(ir_b[0]), .DIN(din_b),
        .ABORT(ab_b), .OUT_VALID(ov_b[0]), .OUT_READY(or_b), .DOUT(dout_b[0]),
        .ZERO_ERR(ze_b[0]));

    gf2m_inv_chain #(.M(233), .SQ_PER_CYCLE(4), .DIGIT(8)) u_dut_sq4 (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_b), .IN_READY(ir_b[1]), .DIN(din_b),
        .ABORT(ab_b), .OUT_VALID(ov_b[1]), .OUT_READY(or_b), .DOUT(dout_b[1]),
        .ZERO_ERR(ze_b[1]));

    gf2m_inv_chain #(.M(233), .SQ_PER_CYCLE(8), .DIGIT(8)) u_dut_sq8 (
        .CLK(CLK), .RST(RST), .IN_VALID(iv_b), .IN_READY(ir_b[2]), .DIN(din_b),
        .ABORT(ab_b), .OUT_VALID(ov_b[2]), .OUT_READY(or_b), .DOUT(dout_b[2]),
        .ZERO_ERR(ze_b[2]));

    // Schoolbook polynomial-basis multiply, one bit of b at a time, reduced on the fly.
    function automatic logic [255:0] gf_mul(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] poly, input int m);
        logic [255:0] r;
        logic         top;
        r = '0;
        for (int i = m - 1; i >= 0; i--) begin
            top  = r[m-1];
            r    = r << 1;
            r[m] = 1'b0;
            if (top)  r = r ^ poly;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_inv8(input logic [7:0] a);
        for (int c = 1; c < 256; c++) begin
            if (gf_mul(256'(a), 256'(c), P8, 8) == 256'd1) return 8'(c);
        end
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] exp,
                        input logic exp_z, input int exp_lat);
        int cyc;
        check({tag, ".in_ready"}, 256'(in_ready8), 256'(1));
        din8 = a;
        in_valid8 = 1'b1;
        @(posedge CLK); #1;
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check({tag, ".latency"}, 256'(cyc), 256'(exp_lat));
        check({tag, ".dout"}, 256'(dout8), 256'(exp));
        check({tag, ".zero_err"}, 256'(zero8), 256'(exp_z));
        $display("txn %s din=%02h dout=%02h zero_err=%b latency=%0d", tag, a, dout8, zero8, cyc);
        @(posedge CLK); #1;
    endtask

    initial begin
        int           cyc;
        logic         seen;
        logic [7:0]   r8;
        logic [255:0] w;

        repeat (3) @(posedge CLK);
        #1;
        check("reset.in_ready", 256'(in_ready8), 256'(1));
        check("reset.out_valid", 256'(out_valid8), 256'(0));
        check("reset.dout", 256'(dout8), 256'(0));
        check("reset.zero_err", 256'(zero8), 256'(0));
        RST = 1'b0;
        @(posedge CLK); #1;
        check("idle.in_ready_233", 256'(ir_b), 256'(3'b111));

        run8("m8_53", 8'h53, 8'hCA, 1'b0, 43);
        run8("m8_01", 8'h01, 8'h01, 1'b0, 43);
        run8("m8_02", 8'h02, 8'h8D, 1'b0, 43);
        run8("m8_00", 8'h00, 8'h00, 1'b1, 1);
        for (int n = 0; n < 8; n++) begin
            r8 = 8'($urandom_range(1, 255));
            run8("m8_rand", r8, ref_inv8(r8), 1'b0, 43);
        end

        // Output back-pressure: result must hold and new operands must be ignored.
        out_ready8 = 1'b0;
        din8 = 8'h53;
        in_valid8 = 1'b1;
        @(posedge CLK); #1;
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("stall.reached_done", 256'(out_valid8), 256'(1));
        for (int i = 0; i < 20; i++) begin
            check("stall.out_valid", 256'(out_valid8), 256'(1));
            check("stall.dout", 256'(dout8), 256'(8'hCA));
            check("stall.in_ready", 256'(in_ready8), 256'(0));
            in_valid8 = i[0];
            din8 = 8'h02;
            @(posedge CLK); #1;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge CLK); #1;
        check("release.out_valid", 256'(out_valid8), 256'(0));
        check("release.in_ready", 256'(in_ready8), 256'(1));
        check("release.dout_kept", 256'(dout8), 256'(8'hCA));
        $display("txn stall din=53 dout=%02h held 20 cycles", dout8);

        // Abort while the first multiply is in flight.
        din8 = 8'h53;
        in_valid8 = 1'b1;
        @(posedge CLK); #1;
        in_valid8 = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        abort8 = 1'b1;
        @(posedge CLK); #1;
        abort8 = 1'b0;
        check("abort.in_ready", 256'(in_ready8), 256'(1));
        check("abort.out_valid", 256'(out_valid8), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            seen = seen | out_valid8;
        end
        check("abort.no_result", 256'(seen), 256'(0));
        $display("txn abort din=53 cancelled");
        run8("after_abort", 8'h53, 8'hCA, 1'b0, 43);

        // Asynchronous reset in the middle of the first squaring step.
        din8 = 8'h53;
        in_valid8 = 1'b1;
        @(posedge CLK); #1;
        in_valid8 = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("areset.in_ready", 256'(in_ready8), 256'(1));
        check("areset.out_valid", 256'(out_valid8), 256'(0));
        check("areset.dout", 256'(dout8), 256'(0));
        check("areset.zero_err", 256'(zero8), 256'(0));
        $display("txn async_reset mid-operation");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        run8("after_reset", 8'h53, 8'hCA, 1'b0, 43);

        // GF(2^233): random nonzero operands on three squarer widths.
        for (int n = 0; n < 41; n++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            din_b = (n == 40) ? 233'd0 : w[232:0];
            if (n != 40 && din_b == '0) din_b = 233'd1;
            check("m233.in_ready", 256'(ir_b), 256'(3'b111));
            iv_b = 1'b1;
            @(posedge CLK); #1;
            iv_b = 1'b0;
            cyc = 0;
            while (ov_b != 3'b111 && cyc < 3000) begin
                @(posedge CLK); #1;
                cyc++;
            end
            check("m233.all_done", 256'(ov_b), 256'(3'b111));
            if (n == 40) begin
                check("m233.zero_dout", 256'(dout_b[0]), 256'(0));
                check("m233.zero_err", 256'(ze_b), 256'(3'b111));
            end else begin
                check("m233.product", gf_mul(256'(din_b), 256'(dout_b[0]), P233, 233), 256'd1);
                check("m233.zero_err", 256'(ze_b), 256'(0));
            end
            check("m233.sq4_vs_sq1", 256'(dout_b[1]), 256'(dout_b[0]));
            check("m233.sq8_vs_sq1", 256'(dout_b[2]), 256'(dout_b[0]));
            $display("txn m233 #%0d din=%059h dout=%059h cycles=%0d", n, din_b, dout_b[0], cyc);
            or_b = 1'b1;
            @(posedge CLK); #1;
            or_b = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
